// File: rtl/store_buffer.sv
// -----------------------------------------------------------------------------
// store_buffer
//
// Write buffer between the processor memory stage and data_memory. Stores are
// queued in a DEPTH-entry FIFO of {word address, data}. A store never uses the
// memory port. The memory port drains the queue one entry per cycle whenever
// no load holds the port. Loads go straight to data_memory with combinational
// read data. Data from the youngest buffered store to the same word is
// forwarded to the load, so the core sees memory in program order.
//
// Optional feature (macro STORE_BUFFER_COALESCE_EN):
//   A store to a word that is already buffered overwrites that entry in place.
//   This is also accepted when the buffer is full. It is not applied to the
//   head entry while the head drains this cycle.
//
// Ports:
//   clock, reset_n        clock, asynchronous active-low reset
//   cpu_mem_write/read    store / load request from the core
//   cpu_address           byte address (word index = address >> 2)
//   cpu_write_data        store data
//   cpu_read_data         load data, combinational, 0 when no load
//   cpu_stall             request not accepted this cycle (buffer full)
//   dm_mem_write/read,
//   dm_address,
//   dm_write_data         request to data_memory
//   dm_read_data          combinational read data from data_memory
//   count, empty          occupancy
// -----------------------------------------------------------------------------
module store_buffer #(
    parameter int DEPTH      = 4,
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 64
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     cpu_mem_write,
    input  logic                     cpu_mem_read,
    input  logic [ADDR_WIDTH-1:0]    cpu_address,
    input  logic [DATA_WIDTH-1:0]    cpu_write_data,
    output logic [DATA_WIDTH-1:0]    cpu_read_data,
    output logic                     cpu_stall,
    output logic                     dm_mem_write,
    output logic                     dm_mem_read,
    output logic [ADDR_WIDTH-1:0]    dm_address,
    output logic [DATA_WIDTH-1:0]    dm_write_data,
    input  logic [DATA_WIDTH-1:0]    dm_read_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int WA_W  = ADDR_WIDTH - 2;

    // Entry storage. Only the valid bits and pointers are reset. Payloads are
    // qualified by valid_q, so they need no reset.
    logic [DEPTH-1:0]      valid_q, valid_d;
    logic [WA_W-1:0]       addr_q [DEPTH];
    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [PTR_W-1:0]      head_q, head_d;
    logic [PTR_W-1:0]      tail_q, tail_d;
    logic [CNT_W-1:0]      count_q, count_d;

    logic [WA_W-1:0]       cpu_word;
    logic [DEPTH-1:0]      match;
    logic                  full;
    logic                  is_empty;
    logic                  drain;
    logic                  load_go;
    logic                  store_go;
    logic                  enq;
    logic                  coal_hit;
    logic [PTR_W-1:0]      coal_idx;
    logic                  fwd_hit;
    logic [DATA_WIDTH-1:0] fwd_data;
    logic [PTR_W-1:0]      fwd_idx;
    logic                  unused_addr_bits;

    assign cpu_word         = cpu_address[ADDR_WIDTH-1:2];
    // Byte offset within a word does not take part in matching.
    assign unused_addr_bits = ^cpu_address[1:0];

    // Per-entry word-address comparators.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
            assign match[gi] = valid_q[gi] && (addr_q[gi] == cpu_word);
        end
    endgenerate

    assign full     = (count_q == CNT_W'(DEPTH));
    assign is_empty = (count_q == '0);

    // Port arbitration. A full buffer always drains. Otherwise any asserted
    // cpu_mem_read holds the port and blocks the drain. This also holds when
    // the read comes together with a store, which then behaves as a store
    // only. In every other case a non-empty buffer drains.
    assign drain   = full || (!cpu_mem_read && !is_empty);
    assign load_go = cpu_mem_read && !cpu_mem_write && !full;

`ifdef STORE_BUFFER_COALESCE_EN
    // At most one entry exists per word, so at most one bit of match is set.
    // The head is excluded while it drains: it leaves the buffer at this edge.
    always_comb begin
        coal_hit = 1'b0;
        coal_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (match[i] && !(drain && (PTR_W'(i) == head_q))) begin
                coal_hit = 1'b1;
                coal_idx = PTR_W'(i);
            end
        end
    end
`else
    assign coal_hit = 1'b0;
    assign coal_idx = '0;
`endif

    assign cpu_stall = full && (cpu_mem_write || cpu_mem_read)
                       && !(cpu_mem_write && coal_hit);
    assign store_go  = cpu_mem_write && !cpu_stall;
    assign enq       = store_go && !coal_hit;

    // Youngest-match forwarding. The valid entries are contiguous from the
    // head. Scanning oldest to youngest lets the last hit win.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        fwd_idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = head_q + PTR_W'(i);
            if (match[fwd_idx]) begin
                fwd_hit  = 1'b1;
                fwd_data = data_q[fwd_idx];
            end
        end
    end

    assign cpu_read_data = load_go ? (fwd_hit ? fwd_data : dm_read_data) : '0;

    always_comb begin
        dm_mem_write  = 1'b0;
        dm_mem_read   = 1'b0;
        dm_address    = '0;
        dm_write_data = '0;
        if (drain) begin
            dm_mem_write  = 1'b1;
            dm_address    = {addr_q[head_q], 2'b00};
            dm_write_data = data_q[head_q];
        end else if (load_go) begin
            dm_mem_read = 1'b1;
            dm_address  = cpu_address;
        end
    end

    always_comb begin
        valid_d = valid_q;
        if (drain) begin
            valid_d[head_q] = 1'b0;
        end
        if (enq) begin
            valid_d[tail_q] = 1'b1;
        end
        head_d  = head_q + PTR_W'(drain);
        tail_d  = tail_q + PTR_W'(enq);
        count_d = count_q + CNT_W'(enq) - CNT_W'(drain);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (enq) begin
            addr_q[tail_q] <= cpu_word;
            data_q[tail_q] <= cpu_write_data;
        end
        if (store_go && coal_hit) begin
            data_q[coal_idx] <= cpu_write_data;
        end
    end

    assign count = count_q;
    assign empty = is_empty;

endmodule

// File: tb/tb_store_buffer.sv
// -----------------------------------------------------------------------------
// tb_store_buffer
//
// Directed scenarios, then randomized traffic, for store_buffer. The bench
// contains a small data_memory. The reference model keeps the pending stores
// as a queue of {word, data} and keeps an array image of memory. Expected
// outputs are derived from the buffer rules for every cycle.
// -----------------------------------------------------------------------------
module tb_store_buffer;

    localparam int DEPTH = 4;
    localparam int DW    = 64;
    localparam int AW    = 64;

    logic          clock;
    logic          reset_n;
    logic          cpu_mem_write;
    logic          cpu_mem_read;
    logic [AW-1:0] cpu_address;
    logic [DW-1:0] cpu_write_data;
    logic [DW-1:0] cpu_read_data;
    logic          cpu_stall;
    logic          dm_mem_write;
    logic          dm_mem_read;
    logic [AW-1:0] dm_address;
    logic [DW-1:0] dm_write_data;
    logic [DW-1:0] dm_read_data;
    logic [$clog2(DEPTH):0] count;
    logic          empty;

    store_buffer #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .cpu_mem_write  (cpu_mem_write),
        .cpu_mem_read   (cpu_mem_read),
        .cpu_address    (cpu_address),
        .cpu_write_data (cpu_write_data),
        .cpu_read_data  (cpu_read_data),
        .cpu_stall      (cpu_stall),
        .dm_mem_write   (dm_mem_write),
        .dm_mem_read    (dm_mem_read),
        .dm_address     (dm_address),
        .dm_write_data  (dm_write_data),
        .dm_read_data   (dm_read_data),
        .count          (count),
        .empty          (empty)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // data_memory: combinational read, write at posedge, 256 words.
    logic [DW-1:0] mem [256];
    logic          mem_init;

    assign dm_read_data = dm_mem_read ? mem[dm_address[9:2]] : '0;

    always @(posedge clock) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= '0;
            mem[8'hFF] <= 64'h2222;
        end else if (dm_mem_write) begin
            mem[dm_address[9:2]] <= dm_write_data;
        end
    end

    // Reference model
    typedef struct packed {
        logic [AW-3:0] waddr;
        logic [DW-1:0] data;
    } entry_t;

    entry_t        q[$];
    logic [DW-1:0] ref_mem [256];

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle. Inputs are driven just after a posedge. Outputs are
    // checked mid-cycle. The model advances at the next posedge.
    task automatic step(input logic wr, input logic rd,
                        input logic [63:0] a, input logic [63:0] d);
        int            n;
        bit            full;
        bit            ld;
        bit            drain;
        bit            coal;
        bit            stall;
        bit            found;
        int            k;
        logic [63:0]   exp_rd;
        cpu_mem_write  = wr;
        cpu_mem_read   = rd;
        cpu_address    = a;
        cpu_write_data = d;
        #4;
        n     = q.size();
        full  = (n == DEPTH);
        ld    = rd && !wr;
        drain = full || (!rd && n > 0);
        coal  = 1'b0;
        k     = -1;
`ifdef STORE_BUFFER_COALESCE_EN
        if (wr) begin
            for (int j = 0; j < n; j++) begin
                if (q[j].waddr == a[63:2] && !(j == 0 && drain)) begin
                    coal = 1'b1;
                    k    = j;
                end
            end
        end
`endif
        stall = full && (wr || rd) && !(wr && coal);

        chk("stall", 64'(cpu_stall), 64'(stall));
        chk("count", 64'(count), 64'(n));
        chk("empty", 64'(empty), 64'(n == 0));
        if (drain) begin
            chk("drain_we",   64'(dm_mem_write), 64'd1);
            chk("drain_re",   64'(dm_mem_read),  64'd0);
            chk("drain_addr", dm_address,        {q[0].waddr, 2'b00});
            chk("drain_data", dm_write_data,     q[0].data);
        end else if (ld) begin
            chk("load_we",   64'(dm_mem_write), 64'd0);
            chk("load_re",   64'(dm_mem_read),  64'd1);
            chk("load_addr", dm_address,        a);
        end else begin
            chk("idle_we", 64'(dm_mem_write), 64'd0);
            chk("idle_re", 64'(dm_mem_read),  64'd0);
            if (n == 0 && !wr && !rd) begin
                chk("idle_addr", dm_address,    64'd0);
                chk("idle_data", dm_write_data, 64'd0);
            end
        end
        if (ld && !stall) begin
            found  = 1'b0;
            exp_rd = ref_mem[a[9:2]];
            for (int j = n - 1; j >= 0; j--) begin
                if (!found && q[j].waddr == a[63:2]) begin
                    found  = 1'b1;
                    exp_rd = q[j].data;
                end
            end
            chk("rdata", cpu_read_data, exp_rd);
        end else if (!ld) begin
            chk("rdata_zero", cpu_read_data, 64'd0);
        end
        $display("step wr=%0d rd=%0d addr=0x%0h data=0x%0h stall=%0d count=%0d rdata=0x%0h",
                 wr, rd, a, d, cpu_stall, count, cpu_read_data);

        @(posedge clock);
        if (coal) q[k].data = d;
        if (drain) begin
            ref_mem[q[0].waddr[7:0]] = q[0].data;
            void'(q.pop_front());
        end
        if (wr && !stall && !coal) q.push_back('{waddr: a[63:2], data: d});
        #1;
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) step(1'b0, 1'b0, 64'd0, 64'd0);
    endtask

    initial begin
        logic [63:0] ra;
        logic        rwr;
        logic        rrd;

        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
        ref_mem[8'hFF] = 64'h2222;
        mem_init       = 1'b1;
        reset_n        = 1'b0;
        cpu_mem_write  = 1'b0;
        cpu_mem_read   = 1'b0;
        cpu_address    = '0;
        cpu_write_data = '0;

        // Reset state
        #3;
        chk("rst_count", 64'(count),         64'd0);
        chk("rst_empty", 64'(empty),         64'd1);
        chk("rst_stall", 64'(cpu_stall),     64'd0);
        chk("rst_we",    64'(dm_mem_write),  64'd0);
        chk("rst_re",    64'(dm_mem_read),   64'd0);
        chk("rst_addr",  dm_address,         64'd0);
        chk("rst_rdata", cpu_read_data,      64'd0);
        #9;
        mem_init = 1'b0;
        reset_n  = 1'b1;
        @(posedge clock);
        #1;

        // Single store drain, then a load of the drained word from memory
        step(1'b1, 1'b0, 64'h10, 64'h100);
        idle(2);
        step(1'b0, 1'b1, 64'h10, 64'd0);
        chk("mem_10", mem[8'h04], 64'h100);

        // Reset mid-operation: three pending stores, the read holds off drains
        step(1'b1, 1'b1, 64'h30, 64'h333);
        step(1'b1, 1'b1, 64'h34, 64'h334);
        step(1'b1, 1'b1, 64'h38, 64'h338);
        chk("pre_rst_count", 64'(count), 64'd3);
        reset_n = 1'b0;
        #2;
        chk("mid_rst_count", 64'(count),        64'd0);
        chk("mid_rst_empty", 64'(empty),        64'd1);
        chk("mid_rst_we",    64'(dm_mem_write), 64'd0);
        q.delete();
        reset_n = 1'b1;
        idle(2);
        step(1'b0, 1'b1, 64'h30, 64'd0);
        chk("mem_30_old", mem[8'h0C], 64'd0);

        // Forwarding: the load hits the buffered store, the port serves the load
        step(1'b1, 1'b0, 64'h20, 64'hAAAA);
        step(1'b0, 1'b1, 64'h20, 64'd0);
        idle(1);

        // Youngest wins
        step(1'b1, 1'b1, 64'h80, 64'hAAAA);
        step(1'b0, 1'b1, 64'h0,  64'd0);
        step(1'b1, 1'b1, 64'h80, 64'hBBBB);
`ifdef STORE_BUFFER_COALESCE_EN
        chk("yw_count", 64'(count), 64'd1);
`else
        chk("yw_count", 64'(count), 64'd2);
`endif
        step(1'b0, 1'b1, 64'h80, 64'd0);
        idle(3);
        chk("mem_80", mem[8'h20], 64'hBBBB);

        // Full and stall
        step(1'b1, 1'b1, 64'h10, 64'h100);
        step(1'b1, 1'b1, 64'h20, 64'h200);
        step(1'b1, 1'b1, 64'h30, 64'h300);
        step(1'b1, 1'b1, 64'h40, 64'h400);
        step(1'b1, 1'b0, 64'h50, 64'h500);   // full: stall with a forced drain of 0x10
        step(1'b1, 1'b0, 64'h50, 64'h500);   // accepted now
        idle(5);
        chk("full_mem_10", mem[8'h04], 64'h100);
        chk("full_mem_20", mem[8'h08], 64'h200);
        chk("full_mem_30", mem[8'h0C], 64'h300);
        chk("full_mem_40", mem[8'h10], 64'h400);
        chk("full_mem_50", mem[8'h14], 64'h500);

        // Miss passthrough
        step(1'b1, 1'b1, 64'h3F8, 64'h1111);
        step(1'b0, 1'b1, 64'h3FC, 64'd0);
        chk("miss_rdata", cpu_read_data, 64'h2222);
        idle(2);

        // Randomized traffic over a small set of words to provoke hits
        for (int i = 0; i < 400; i++) begin
            ra  = 64'h100 + 64'(4 * $urandom_range(0, 5)) + 64'($urandom_range(0, 3));
            rwr = ($urandom_range(0, 2) == 0);
            rrd = ($urandom_range(0, 1) == 0);
            step(rwr, rrd, ra, {$urandom, $urandom});
        end
        idle(DEPTH + 2);
        chk("final_empty", 64'(empty), 64'd1);
        for (int i = 0; i < 256; i++) begin
            chk($sformatf("mem[%0d]", i), mem[i], ref_mem[i]);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
